// File: rtl/spi_mailbox_slave.sv
// SPI mode-0 (MSB first) slave exposing the 8-byte Z80 mailbox to the MCU; all pins are oversampled in clk.
// Optional feature: define SPI_MAILBOX_IRQ_EN to flag Z80-side mailbox changes on mcu_irq.
module spi_mailbox_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [63:0] z80_to_spi_flat,
  output logic [63:0] spi_to_z80_flat,
  output logic        wr_strobe,
  output logic [2:0]  wr_index,
  output logic        mcu_irq
);
  typedef enum logic [1:0] {IDLE, CMD, DATA, SKIP} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sck_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic       sck_d_reg, cs_d_reg;
  logic       sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall, byte_done;
  logic [2:0] bit_cnt_reg;
  logic [7:0] rx_reg, rx_next, tx_reg;
  logic       w_reg, ai_reg;
  logic [2:0] idx_reg, idx_step;
  logic       wr_pend_reg;
  logic [7:0] wr_data_reg;
  logic [2:0] wr_idx_reg;
  logic       decode_ok, data_done;
  logic [7:0] z80_byte [8];
  logic [7:0] mbox_reg [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_byte
      assign z80_byte[gi] = z80_to_spi_flat[8*gi +: 8];
      assign spi_to_z80_flat[8*gi +: 8] = mbox_reg[gi];
    end
  endgenerate

  assign sck_s     = sck_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_d_reg;
  assign sck_fall  = ~sck_s & sck_d_reg;
  assign cs_fall   = cs_d_reg & ~cs_s;
  assign rx_next   = {rx_reg[6:0], mosi_s};
  // A rise that coincides with cs_n high never counts, so cs_n always wins.
  assign byte_done = ~cs_s & sck_rise & (bit_cnt_reg == 3'd7);
  assign idx_step  = ai_reg ? idx_reg + 3'd1 : idx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_reg  <= '0;
      cs_sync_reg   <= '0;
      mosi_sync_reg <= '0;
      sck_d_reg     <= 1'b0;
      cs_d_reg      <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], spi_sck};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      sck_d_reg     <= sck_s;
      cs_d_reg      <= cs_s;
    end
  end

  always_comb begin
    state_next = state_reg;
    decode_ok  = 1'b0;
    data_done  = 1'b0;
    case (state_reg)
      IDLE: if (cs_fall) state_next = CMD;
      CMD: begin
        if (cs_s) state_next = IDLE;
        else if (byte_done) begin
          if (rx_next[5:3] != 3'b000) state_next = SKIP;
          else begin
            state_next = DATA;
            decode_ok  = 1'b1;
          end
        end
      end
      DATA: begin
        if (cs_s) state_next = IDLE;
        else if (byte_done) data_done = 1'b1;
      end
      SKIP: if (cs_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      rx_reg      <= 8'h00;
      tx_reg      <= 8'h00;
      spi_miso    <= 1'b0;
      w_reg       <= 1'b0;
      ai_reg      <= 1'b0;
      idx_reg     <= 3'd0;
      wr_pend_reg <= 1'b0;
      wr_data_reg <= 8'h00;
      wr_idx_reg  <= 3'd0;
      wr_strobe   <= 1'b0;
      wr_index    <= 3'd0;
      for (int i = 0; i < 8; i++) mbox_reg[i] <= RST_VAL;
    end else begin
      state_reg   <= state_next;
      wr_pend_reg <= 1'b0;
      wr_strobe   <= wr_pend_reg;
      if (wr_pend_reg) begin
        wr_index             <= wr_idx_reg;
        mbox_reg[wr_idx_reg] <= wr_data_reg;
      end

      if (state_reg == IDLE) begin
        bit_cnt_reg <= 3'd0;
        rx_reg      <= 8'h00;
      end else if ((state_reg == CMD || state_reg == DATA) && !cs_s && sck_rise) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        rx_reg      <= rx_next;
      end

      if (decode_ok) begin
        w_reg   <= rx_next[7];
        ai_reg  <= rx_next[6];
        idx_reg <= rx_next[2:0];
        if (!rx_next[7]) begin
          tx_reg   <= z80_byte[rx_next[2:0]];
          spi_miso <= z80_byte[rx_next[2:0]][7];
        end
      end else if (data_done) begin
        idx_reg <= idx_step;
        if (w_reg) begin
          wr_pend_reg <= 1'b1;
          wr_data_reg <= rx_next;
          wr_idx_reg  <= idx_reg;
        end else begin
          tx_reg   <= z80_byte[idx_step];
          spi_miso <= z80_byte[idx_step][7];
        end
      end else if (state_reg == DATA && !w_reg && !cs_s && sck_fall && bit_cnt_reg != 3'd0) begin
        // The fall right after a byte boundary keeps the freshly loaded MSB on the line.
        tx_reg   <= {tx_reg[6:0], 1'b0};
        spi_miso <= tx_reg[6];
      end

      if (state_next != DATA) begin
        spi_miso <= 1'b0;
        tx_reg   <= 8'h00;
      end
    end
  end

`ifdef SPI_MAILBOX_IRQ_EN
  logic [63:0] z80_d_reg;
  always_ff @(posedge clk) begin
    z80_d_reg <= z80_to_spi_flat;
    if (rst) mcu_irq <= 1'b0;
    else if (z80_to_spi_flat != z80_d_reg) mcu_irq <= 1'b1;
    else if (decode_ok && !rx_next[7]) mcu_irq <= 1'b0;
  end
`else
  assign mcu_irq = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mailbox_slave.sv
// Bench for spi_mailbox_slave: table vectors, hand-written corner sequences and random frames vs a frame-level model.
module tb_spi_mailbox_slave;
  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [63:0] z80_flat = '0;
  logic [63:0] spi_to_z80_flat;
  logic        wr_strobe;
  logic [2:0]  wr_index;
  logic        mcu_irq;

  spi_mailbox_slave #(.SYNC_STAGES(2), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .z80_to_spi_flat(z80_flat), .spi_to_z80_flat(spi_to_z80_flat),
    .wr_strobe(wr_strobe), .wr_index(wr_index), .mcu_irq(mcu_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  rx_acc;
  logic [7:0]  frame_b [16];
  logic [7:0]  rx_got [16];
  int          frame_n;
  int          part_bits;
  logic [7:0]  part_val;
  logic [10:0] wq [$];

  typedef struct {
    logic [63:0] z80;
    int          nb;
    logic [31:0] tx;
    logic [31:0] rx;
    bit          chk_rx;
    int          nwr;
    logic [2:0]  wfirst;
    logic [63:0] mb;
  } vec_t;
  vec_t vecs [6];

  // Every committed write as seen on the outputs: {index, mailbox byte at that index}.
  always @(negedge clk) begin
    if (wr_strobe) wq.push_back({wr_index, spi_to_z80_flat[8*int'(wr_index) +: 8]});
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[7-i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      rx_acc  = {rx_acc[6:0], spi_miso};
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_assert();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_release();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (HALF + 4) @(negedge clk);
  endtask

  task automatic do_frame();
    wq.delete();
    cs_assert();
    for (int k = 0; k < frame_n; k++) begin
      send_bits(frame_b[k], 8);
      rx_got[k] = rx_acc;
    end
    if (part_bits > 0) send_bits(part_val, part_bits);
    cs_release();
    $display("frame cmd=%h bytes=%0d partial=%0d writes=%0d", frame_b[0], frame_n, part_bits, wq.size());
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  logic [63:0] mb_exp;
  logic [7:0]  g1, g2;
  int          lat;
  logic [7:0]  cmd, exp_b;
  logic [7:0]  mb_m [8];
  logic [10:0] exp_wq [$];
  logic [63:0] mb_pack;
  int          idx;

  initial begin
    vecs[0] = '{64'h0, 3, {8'hC2, 8'hA5, 8'h5A, 8'h00}, 32'h0, 1'b0, 2, 3'd2, 64'h00000000_5AA50000};
    vecs[1] = '{64'h00003C00_00000000, 3, {8'h05, 8'h00, 8'h00, 8'h00}, {8'h00, 8'h3C, 8'h3C, 8'h00}, 1'b1, 0, 3'd0, 64'h00000000_5AA50000};
    vecs[2] = '{64'h88776655_44332211, 4, {8'h47, 8'h00, 8'h00, 8'h00}, {8'h00, 8'h88, 8'h11, 8'h22}, 1'b1, 0, 3'd0, 64'h00000000_5AA50000};
    vecs[3] = '{64'h88776655_44332211, 2, {8'h88, 8'hFF, 8'h00, 8'h00}, 32'h0, 1'b1, 0, 3'd0, 64'h00000000_5AA50000};
    vecs[4] = '{64'h88776655_44332211, 2, {8'h81, 8'h12, 8'h00, 8'h00}, 32'h0, 1'b0, 1, 3'd1, 64'h00000000_5AA51200};
    vecs[5] = '{64'h0, 4, {8'hC7, 8'h01, 8'h02, 8'h03}, 32'h0, 1'b0, 3, 3'd7, 64'h01000000_5AA50302};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_mailbox", spi_to_z80_flat, 64'h0);
    check("rst_miso", {63'h0, spi_miso}, 64'h0);
    check("rst_strobe", {63'h0, wr_strobe}, 64'h0);
    check("rst_index", {61'h0, wr_index}, 64'h0);
    check("rst_irq", {63'h0, mcu_irq}, 64'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Abort: command plus half a data byte must not commit anything
    frame_b[0] = 8'h81; frame_n = 1; part_bits = 4; part_val = 8'hF0;
    do_frame();
    check("abort_nwr", 64'(wq.size()), 64'd0);
    check("abort_byte1", {56'h0, spi_to_z80_flat[15:8]}, 64'h00);

    // Table vectors
    part_bits = 0;
    for (int v = 0; v < 6; v++) begin
      z80_flat = vecs[v].z80;
      frame_n  = vecs[v].nb;
      for (int k = 0; k < vecs[v].nb; k++) frame_b[k] = vecs[v].tx[31-8*k -: 8];
      do_frame();
      if (vecs[v].chk_rx)
        for (int k = 0; k < vecs[v].nb; k++)
          check($sformatf("vec%0d_miso%0d", v, k), {56'h0, rx_got[k]}, {56'h0, vecs[v].rx[31-8*k -: 8]});
      check($sformatf("vec%0d_nwr", v), 64'(wq.size()), 64'(vecs[v].nwr));
      if (vecs[v].nwr > 0 && wq.size() > 0)
        check($sformatf("vec%0d_widx", v), {61'h0, wq[0][10:8]}, {61'h0, vecs[v].wfirst});
      check($sformatf("vec%0d_mailbox", v), spi_to_z80_flat, vecs[v].mb);
      check($sformatf("vec%0d_irq", v), {63'h0, mcu_irq}, 64'h0);
    end
    mb_exp = vecs[5].mb;

    // Snapshot: Z80 changes byte0 mid-byte; the byte in flight keeps the old value
    z80_flat = 64'hA1;
    cs_assert();
    send_bits(8'h00, 8);
    send_bits(8'h00, 2);
    z80_flat = 64'hB2;
    send_bits(8'h00, 6);
    g1 = rx_acc;
    send_bits(8'h00, 8);
    g2 = rx_acc;
    cs_release();
    $display("snapshot read got %h then %h", g1, g2);
    check("snap_old", {56'h0, g1}, 64'hA1);
    check("snap_new", {56'h0, g2}, 64'hB2);

    // cs_n rise together with the 8th sck rise: byte discarded
    wq.delete();
    cs_assert();
    send_bits(8'h84, 8);
    send_bits(8'hFF, 7);
    spi_mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b1; spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b0;
    repeat (HALF + 4) @(negedge clk);
    $display("cs/sck coincident frame writes=%0d", wq.size());
    check("coinc_nwr", 64'(wq.size()), 64'd0);
    check("coinc_mailbox", spi_to_z80_flat, mb_exp);

    // Pin sck rise to commit latency: SYNC_STAGES+2 clocks
    wq.delete();
    cs_assert();
    send_bits(8'h83, 8);
    send_bits(8'h77, 7);
    spi_mosi = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b1;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (wr_strobe) break;
    end
    repeat (HALF) @(negedge clk);
    spi_sck = 1'b0;
    cs_release();
    mb_exp[31:24] = 8'h77;
    $display("write latency %0d clocks", lat);
    check("latency", 64'(lat), 64'd4);
    check("lat_mailbox", spi_to_z80_flat, mb_exp);

    // Reset in the middle of a write data byte
    wq.delete();
    cs_assert();
    send_bits(8'hC0, 8);
    send_bits(8'hFF, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_mailbox", spi_to_z80_flat, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_miso", {63'h0, spi_miso}, 64'h0);
    cs_release();
    check("midrst_nwr", 64'(wq.size()), 64'd0);
    frame_b[0] = 8'h86; frame_b[1] = 8'h9C; frame_n = 2; part_bits = 0;
    do_frame();
    check("postrst_nwr", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) check("postrst_widx", {61'h0, wq[0][10:8]}, 64'd6);
    check("postrst_mailbox", spi_to_z80_flat, 64'h009C0000_00000000);

    // Random frames against a frame-level model
    pulse_reset();
    for (int i = 0; i < 8; i++) mb_m[i] = 8'h00;
    for (int f = 0; f < 25; f++) begin
      z80_flat = {$urandom(), $urandom()};
      cmd = 8'($urandom());
      if ($urandom_range(0, 7) == 0) begin
        if (cmd[5:3] == 3'b000) cmd[5:3] = 3'b101;
      end else cmd[5:3] = 3'b000;
      frame_b[0] = cmd;
      frame_n = 1 + $urandom_range(0, 8);
      for (int k = 1; k < frame_n; k++) frame_b[k] = 8'($urandom());
      part_bits = $urandom_range(0, 7);
      part_val  = 8'($urandom());
      do_frame();

      exp_wq.delete();
      idx = int'(cmd[2:0]);
      for (int k = 0; k < frame_n; k++) begin
        if (k == 0 || cmd[5:3] != 3'b000) begin
          check($sformatf("rnd%0d_miso%0d", f, k), {56'h0, rx_got[k]}, 64'h0);
        end else if (!cmd[7]) begin
          exp_b = z80_flat[8*idx +: 8];
          check($sformatf("rnd%0d_miso%0d", f, k), {56'h0, rx_got[k]}, {56'h0, exp_b});
          if (cmd[6]) idx = (idx + 1) % 8;
        end else begin
          mb_m[idx] = frame_b[k];
          exp_wq.push_back({3'(idx), frame_b[k]});
          if (cmd[6]) idx = (idx + 1) % 8;
        end
      end
      check($sformatf("rnd%0d_nwr", f), 64'(wq.size()), 64'(exp_wq.size()));
      for (int i = 0; i < exp_wq.size() && i < wq.size(); i++)
        check($sformatf("rnd%0d_wr%0d", f, i), {53'h0, wq[i]}, {53'h0, exp_wq[i]});
      for (int i = 0; i < 8; i++) mb_pack[8*i +: 8] = mb_m[i];
      check($sformatf("rnd%0d_mailbox", f), spi_to_z80_flat, mb_pack);
      check($sformatf("rnd%0d_irq", f), {63'h0, mcu_irq}, 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_mailbox_slave.md
Name: spi_mailbox_slave

Overview:
- SPI slave (mode 0, MSB first) that gives the host MCU access to the 8-byte Z80 mailbox.
- MCU writes land in spi_to_z80_flat, which the Z80 reads over I/O. MCU reads return bytes from z80_to_spi_flat, which the Z80 writes.
- All SPI pins are oversampled in the clk domain. There is no SCK-domain logic.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on spi_sck/spi_mosi/spi_cs_n (min 2)
- RST_VAL, 8'h00, reset value of every spi_to_z80 byte

Ports:
- clk  input  1  system clock; must be >= 8x SCK frequency
- rst  input  1  synchronous, active-high reset
- spi_sck  input  1  SPI clock from MCU, idle low
- spi_cs_n  input  1  chip select, active low
- spi_mosi  input  1  MCU to FPGA data
- spi_miso  output  1  FPGA to MCU data, registered
- z80_to_spi_flat  input  64  mailbox bytes written by Z80; byte i = bits [8i+7:8i]
- spi_to_z80_flat  output  64  mailbox bytes written by MCU; same packing
- wr_strobe  output  1  one-cycle pulse when a spi_to_z80 byte is updated
- wr_index  output  3  index of the byte updated; valid with wr_strobe
- mcu_irq  output  1  Z80-side-change flag (see Optional Feature)

Behaviour:
- Synchronization:
  - sck, cs_n and mosi each pass through SYNC_STAGES flops.
  - Rise and fall are detected from the last two synced sck samples.
  - mosi is sampled on a detected rise.
- Reset (rst=1 at a clk edge):
  - state=IDLE, bit counter=0, shift registers=0.
  - spi_to_z80 bytes = RST_VAL; spi_miso=0, wr_strobe=0, wr_index=0, mcu_irq=0.
  - Reset mid-transfer aborts the frame; no partial write commits.
- Frame format:
  - Byte 0 is the command: bit7 = W (1 write, 0 read), bit6 = AI (auto-increment), bits5:3 must be 000, bits2:0 = idx.
  - Each following byte is a data byte.
- FSM states:
  - IDLE: synced cs_n high. A falling cs_n goes to CMD with counter=0.
  - CMD: shift 8 bits. On the 8th rise, decode. Nonzero bits5:3 go to SKIP; otherwise latch W/AI/idx and go to DATA.
  - DATA, read:
    - On the CMD-to-DATA transition (same cycle as the 8th rise), load the tx shifter with z80_to_spi[idx] as a snapshot, and drive its MSB on spi_miso.
    - Shift on each sck fall.
    - After the 8th rise of a data byte: if AI, idx = idx+1 mod 8, reload and present the next MSB; else reload the same idx.
  - DATA, write: on the 8th rise of a data byte, the next clk sets spi_to_z80[idx] to the rx byte and pulses wr_strobe with wr_index=idx. Then if AI, idx = idx+1 mod 8.
  - SKIP: ignore sck; spi_miso=0 until cs_n rises.
- cs_n rising in any state:
  - Return to IDLE the next cycle and discard any partial byte (fewer than 8 bits): no write, no idx change.
- spi_miso: 0 in IDLE, CMD and SKIP. Changes only on sck fall or on a load. Never tri-stated (board has a dedicated line).
- Wrap-around: idx 7 with AI goes to 0. Bursts longer than 8 data bytes keep wrapping.
- Simultaneous events:
  - A Z80 change to z80_to_spi during a read byte does not alter the byte in flight; the snapshot holds.
  - cs_n rise and sck rise in the same synced cycle: cs_n wins and the byte is discarded.
- Latency:
  - Pin sck rise to commit: SYNC_STAGES+2 clk.
  - wr_strobe is coincident with the register update.

Optional Feature:
- Macro: SPI_MAILBOX_IRQ_EN.
- Defined:
  - A 64-bit delayed copy of z80_to_spi_flat is compared each cycle. Any difference sets mcu_irq.
  - mcu_irq clears on the cycle the CMD byte of a read frame is decoded.
  - A set and a clear in the same cycle resolve to set.
- Undefined: mcu_irq is tied 0 and the compare logic is absent.

Test Plan:
- Write with AI: CS low, send 0xC2, 0xA5, 0x5A, CS high -> byte2=0xA5, byte3=0x5A; two wr_strobe pulses with wr_index 2 then 3; other bytes 0x00.
- Read without AI: z80_to_spi byte5=0x3C; send 0x05, 0x00, 0x00 -> MISO returns 0x00, 0x3C, 0x3C.
- Read burst wrap: z80_to_spi = {88,77,66,55,44,33,22,11} (byte7..0); send 0x47 plus 3 dummy bytes -> MISO data 88, 11, 22.
- Abort: send 0x81, then 4 bits of 0xF0, CS high -> byte1 unchanged, no wr_strobe. Next frame 0x81 0x12 -> byte1=0x12.
- Invalid command 0x88 0xFF -> no write, MISO 0 throughout. Assert rst mid-byte in a write frame -> all bytes 0x00, state IDLE.
- With SPI_MAILBOX_IRQ_EN: change z80_to_spi byte0 11 to 55 -> mcu_irq=1. Read frame 0x00 -> mcu_irq=0 after CMD decode.
